// File: rtl/fetch_decode.sv
// fetch_decode: combined instruction-fetch / instruction-decode stage.
//   A word is fetched big-endian from a byte-addressed ROM at pc, latched into
//   the IF/ID register instr, and decoded into funct plus two register reads.
//   One register write-back is accepted per clock.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears instr only)
//   regWrite   register-bank write enable
//   writeData  write-back data
//   dir        write-back register address (low 5 bits used)
//   pc         byte address of the instruction to fetch (low 2 bits ignored)
//   funct      instr[5:0]
//   readData1  contents of register rs = instr[25:21] (reg 0 reads 0)
//   readData2  contents of register rt = instr[20:16] (reg 0 reads 0)

// Instruction ROM: combinational, word-aligned, big-endian, no write port.
module fetch_rom #(
   parameter int unsigned ADDR_W     = 7,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned IMEM_BYTES = 128
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] word
);
   // Contents are loaded externally; the initializer only gives a defined start.
   logic [7:0] isa [0:IMEM_BYTES-1] = '{default: 8'h00};

   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic              unused_addr;

   assign a0 = {addr[ADDR_W-1:2], 2'b00};
   assign a1 = {addr[ADDR_W-1:2], 2'b01};
   assign a2 = {addr[ADDR_W-1:2], 2'b10};
   assign a3 = {addr[ADDR_W-1:2], 2'b11};
   assign unused_addr = ^addr[1:0];

   assign word = {isa[a0], isa[a1], isa[a2], isa[a3]};
endmodule

// Register bank: two asynchronous read ports, one synchronous write port.
module reg_bank #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned RA_W   = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   raddr1,
   input  logic [RA_W-1:0]   raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);
   logic [DATA_W-1:0] bank [0:NREGS-1];

   // No reset: preloaded contents must survive rst.
   always_ff @(posedge clk) begin
      if (we && (waddr != '0)) begin
         bank[waddr] <= wdata;
      end
   end

   // Register 0 is hardwired to zero on read, whatever is stored there.
   assign rdata1 = (raddr1 == '0) ? '0 : bank[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : bank[raddr2];
endmodule

module fetch_decode #(
   parameter int unsigned ADDR_W     = 7,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned IMEM_BYTES = 128,
   parameter int unsigned NREGS      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              regWrite,
   input  logic [DATA_W-1:0] writeData,
   input  logic [ADDR_W-1:0] dir,
   input  logic [ADDR_W-1:0] pc,
   output logic [5:0]        funct,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2
);
   localparam int unsigned RA_W = $clog2(NREGS);

   logic [DATA_W-1:0] fetched;
   logic [DATA_W-1:0] instr;
   logic [RA_W-1:0]   rs, rt;
   logic              wr_en;
   logic              unused_bits;

   fetch_rom #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .IMEM_BYTES(IMEM_BYTES)
   ) fc (
      .addr(pc),
      .word(fetched)
   );

   // IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr <= '0;
      end else begin
         instr <= fetched;
      end
   end

   assign funct = instr[5:0];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];

   // A write coincident with reset is dropped.
   assign wr_en = regWrite & ~rst;

   assign unused_bits = ^{instr[DATA_W-1:26], instr[15:6], dir[ADDR_W-1:RA_W]};

   reg_bank #(
      .DATA_W(DATA_W),
      .NREGS (NREGS),
      .RA_W  (RA_W)
   ) rb (
      .clk   (clk),
      .we    (wr_en),
      .waddr (dir[RA_W-1:0]),
      .wdata (writeData),
      .raddr1(rs),
      .raddr2(rt),
      .rdata1(readData1),
      .rdata2(readData2)
   );
endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;
   logic        clk = 1'b0;
   logic        rst;
   logic        regWrite;
   logic [31:0] writeData;
   logic [6:0]  dir;
   logic [6:0]  pc;
   logic [5:0]  funct;
   logic [31:0] readData1;
   logic [31:0] readData2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [69:0] v;   // {funct, readData1, readData2}
   } exp_t;

   exp_t        sbq[$];
   exp_t        e;
   logic [31:0] mrom [0:31];
   logic [31:0] mreg [0:31];

   fetch_decode dut (
      .clk      (clk),
      .rst      (rst),
      .regWrite (regWrite),
      .writeData(writeData),
      .dir      (dir),
      .pc       (pc),
      .funct    (funct),
      .readData1(readData1),
      .readData2(readData2)
   );

   always #5 clk = ~clk;

   // Reference model for the edge about to happen, using the inputs now driven.
   function automatic void push_exp(input string name);
      logic [31:0] w;
      logic [4:0]  s, t;
      exp_t        x;
      if (!rst && regWrite && dir[4:0] != 5'd0) mreg[dir[4:0]] = writeData;
      w = rst ? 32'h0 : mrom[pc[6:2]];
      s = w[25:21];
      t = w[20:16];
      x.name = name;
      x.v = {w[5:0], (s == 5'd0) ? 32'h0 : mreg[s], (t == 5'd0) ? 32'h0 : mreg[t]};
      sbq.push_back(x);
   endfunction

   task automatic load_rom();
      for (int i = 0; i < 32; i++) mrom[i] = $urandom;
      mrom[0]  = 32'h0085_3020;  // add $6,$4,$5 : rs=4 rt=5 funct=0x20
      mrom[1]  = 32'h00E4_4022;  // rs=7 rt=4 funct=0x22
      mrom[2]  = 32'h00A0_4825;  // rs=5 rt=0 funct=0x25
      mrom[3]  = 32'hFC00_003F;  // rs=0 rt=0 funct=0x3F
      mrom[31] = 32'h0064_502A;  // rs=3 rt=4 funct=0x2A
      for (int i = 0; i < 32; i++) begin
         for (int k = 0; k < 4; k++) begin
            dut.fc.isa[4*i+k] = mrom[i][31-8*k -: 8];
         end
      end
   endtask

   task automatic preload_bank();
      logic [4:0]  ra [4];
      logic [31:0] rv [4];
      ra = '{5'd3, 5'd4, 5'd5, 5'd7};
      rv = '{32'h33, 32'd11, 32'd22, 32'h77};
      rst = 1'b0;
      pc  = 7'd0;
      for (int i = 0; i < 4; i++) begin
         regWrite  = 1'b1;
         dir       = {2'b00, ra[i]};
         writeData = rv[i];
         mreg[ra[i]] = rv[i];
         @(posedge clk); #1;
      end
      regWrite = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      regWrite = 1'b0;
      pc = 7'd0;
      for (int i = 0; i < 2; i++) begin
         push_exp("reset");
         @(posedge clk); #1;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL reset: scoreboard empty");
         end else begin
            e = sbq.pop_front();
            checks++;
            if ({funct, readData1, readData2} !== e.v)
               begin errors++; $display("FAIL %s: got %h exp %h", e.name,
                  {funct, readData1, readData2}, e.v); end
         end
      end
      checks++;
      if ({funct, readData1, readData2} !== 70'h0) begin
         errors++;
         $display("FAIL reset_zero: got %h exp 0", {funct, readData1, readData2});
      end
      checks++;
      if (dut.rb.bank[5] !== 32'd22) begin
         errors++;
         $display("FAIL reset_bank5: got %h exp %h", dut.rb.bank[5], 32'd22);
      end
   endtask

   task automatic test_fetch_decode();
      rst = 1'b0;
      pc = 7'd0;
      push_exp("fetch_add");
      @(posedge clk); #1;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL fetch_add: scoreboard empty");
      end else begin
         e = sbq.pop_front();
         checks++;
         if ({funct, readData1, readData2} !== e.v)
            begin errors++; $display("FAIL %s: got %h exp %h", e.name,
               {funct, readData1, readData2}, e.v); end
      end
      checks++;
      if ({funct, readData1, readData2} !== {6'h20, 32'd11, 32'd22}) begin
         errors++;
         $display("FAIL fetch_add_const: got %h exp %h", {funct, readData1, readData2},
            {6'h20, 32'd11, 32'd22});
      end
   endtask

   task automatic test_sequential();
      logic [6:0] pcs [7];
      pcs = '{7'd0, 7'd4, 7'd8, 7'd6, 7'd13, 7'd124, 7'd0};
      for (int i = 0; i < 7; i++) begin
         pc = pcs[i];
         push_exp($sformatf("seq_pc%0d", pcs[i]));
         @(posedge clk); #1;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL seq: scoreboard empty");
         end else begin
            e = sbq.pop_front();
            checks++;
            if ({funct, readData1, readData2} !== e.v)
               begin errors++; $display("FAIL %s: got %h exp %h", e.name,
                  {funct, readData1, readData2}, e.v); end
         end
      end
   endtask

   task automatic test_write_back();
      pc = 7'd0;  // instr already holds word 0 (rs=4)
      regWrite  = 1'b1;
      dir       = 7'd4;
      writeData = 32'd215661399;
      #1;
      checks++;
      if (readData1 !== 32'd11) begin
         errors++;
         $display("FAIL wb_no_bypass: got %h exp %h", readData1, 32'd11);
      end
      push_exp("wb_after_edge");
      @(posedge clk); #1;
      regWrite = 1'b0;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL wb: scoreboard empty");
      end else begin
         e = sbq.pop_front();
         checks++;
         if ({funct, readData1, readData2} !== e.v)
            begin errors++; $display("FAIL %s: got %h exp %h", e.name,
               {funct, readData1, readData2}, e.v); end
      end
      checks++;
      if (readData1 !== 32'd215661399) begin
         errors++;
         $display("FAIL wb_value: got %h exp %h", readData1, 32'd215661399);
      end
   endtask

   task automatic test_reg0();
      logic [6:0]  dirs [3];
      logic [31:0] data [3];
      logic [6:0]  pcs  [3];
      dirs = '{7'd0, 7'd36, 7'd0};
      data = '{32'hFFFF_FFFF, 32'hABCD_1234, 32'h5555_AAAA};
      pcs  = '{7'd12, 7'd0, 7'd8};
      for (int i = 0; i < 3; i++) begin
         regWrite  = 1'b1;
         dir       = dirs[i];
         writeData = data[i];
         pc        = pcs[i];
         push_exp($sformatf("reg0_%0d", i));
         @(posedge clk); #1;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL reg0: scoreboard empty");
         end else begin
            e = sbq.pop_front();
            checks++;
            if ({funct, readData1, readData2} !== e.v)
               begin errors++; $display("FAIL %s: got %h exp %h", e.name,
                  {funct, readData1, readData2}, e.v); end
         end
      end
      regWrite = 1'b0;
      checks++;
      if (readData2 !== 32'h0) begin
         errors++;
         $display("FAIL reg0_rt_zero: got %h exp 0", readData2);
      end
   endtask

   task automatic test_reset_vs_write();
      rst       = 1'b1;
      regWrite  = 1'b1;
      dir       = 7'd3;
      writeData = 32'hDEAD_BEEF;
      pc        = 7'd4;
      push_exp("rst_vs_wr");
      @(posedge clk); #1;
      rst = 1'b0;
      regWrite = 1'b0;
      pc = 7'd124;
      push_exp("rst_vs_wr_read3");
      for (int i = 0; i < 2; i++) begin
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL rst_vs_wr: scoreboard empty");
         end else begin
            e = sbq.pop_front();
            checks++;
            if ({funct, readData1, readData2} !== e.v)
               begin errors++; $display("FAIL %s: got %h exp %h", e.name,
                  {funct, readData1, readData2}, e.v); end
         end
         if (i == 0) begin
            @(posedge clk); #1;
         end
      end
      checks++;
      if (readData1 !== 32'h33) begin
         errors++;
         $display("FAIL rst_vs_wr_bank3: got %h exp %h", readData1, 32'h33);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] words [4];
      words = '{5'd0, 5'd1, 5'd2, 5'd31};
      for (int i = 0; i < 12; i++) begin
         regWrite  = 1'($urandom_range(0, 1));
         dir       = 7'($urandom_range(0, 127));
         writeData = $urandom;
         pc        = {words[$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
         push_exp($sformatf("b2b_%0d", i));
         @(posedge clk); #1;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL b2b: scoreboard empty");
         end else begin
            e = sbq.pop_front();
            checks++;
            if ({funct, readData1, readData2} !== e.v)
               begin errors++; $display("FAIL %s: got %h exp %h", e.name,
                  {funct, readData1, readData2}, e.v); end
         end
      end
      regWrite = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      regWrite  = 1'b0;
      writeData = 32'h0;
      dir       = 7'd0;
      pc        = 7'd0;
      for (int i = 0; i < 32; i++) mreg[i] = 'x;
      #1;
      load_rom();
      @(posedge clk); #1;
      preload_bank();
      test_reset();
      test_fetch_decode();
      test_sequential();
      test_write_back();
      test_reg0();
      test_reset_vs_write();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
